// File: rtl/exec_sequencer_pkg.sv
// Shared opcode constants, state encodings and opcode classification helpers
// for the exec_sequencer control slice.
package exec_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic op_writes_reg(input logic [6:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        return op_writes_reg(op) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the sequencer and its surrounding datapath.
interface exec_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic [6:0]       opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             if_en;
    logic             id_en;
    logic             ex_en;
    logic             mem_en;
    logic             wb_en;
    logic             pc_we;
    logic             reg_we;
    logic [2:0]       state;
    logic             busy;
    logic [CNT_W-1:0] retired;
    logic             illegal;
    logic             timeout;

    modport master (
        output start, halt_req, opcode, imem_ready, dmem_ready,
        input  if_en, id_en, ex_en, mem_en, wb_en, pc_we, reg_we,
               state, busy, retired, illegal, timeout
    );

    modport slave (
        input  start, halt_req, opcode, imem_ready, dmem_ready,
        output if_en, id_en, ex_en, mem_en, wb_en, pc_we, reg_we,
               state, busy, retired, illegal, timeout
    );
endinterface

// File: rtl/exec_sequencer_mem_wait_timer.sv
// Wait-cycle counter for FETCH/MEMORY; flags expiry on the last allowed
// cycle while the awaited ready is still low. TIMEOUT=0 never expires.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    input  logic ready,
    output logic expired
);
    localparam int unsigned W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting && !ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready in the limit cycle masks expiry, so a late response still wins.
    assign expired = (TIMEOUT != 0) && waiting && !ready && (cnt_q == W'(LIMIT));

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// control FSM with halt, illegal-opcode and memory-timeout handling.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    exec_sequencer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             halt_pend_q, halt_pend_d;

    logic waiting;
    logic ready;
    logic clear;
    logic expired;
    logic active;

    always_comb begin
        active  = (state_q != ST_IDLE) && (state_q != ST_HALT);
        waiting = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
        ready   = (state_q == ST_MEMORY) ? bus.dmem_ready : bus.imem_ready;
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .waiting (waiting),
        .ready   (ready),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        halt_pend_d = halt_pend_q;

        if (active && bus.halt_req) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (op_legal(bus.opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                state_d = op_is_mem(bus.opcode) ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (bus.dmem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (expired) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                retired_d = retired_q + 1'b1;
                // A request in the writeback cycle itself still stops here.
                state_d   = (halt_pend_q || bus.halt_req) ? ST_HALT : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
            halt_pend_d = 1'b0;
        end
    end

    assign clear = (state_d != state_q) &&
                   ((state_d == ST_FETCH) || (state_d == ST_MEMORY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        bus.if_en   = (state_q == ST_FETCH);
        bus.id_en   = (state_q == ST_DECODE);
        bus.ex_en   = (state_q == ST_EXECUTE);
        bus.mem_en  = (state_q == ST_MEMORY);
        bus.wb_en   = (state_q == ST_WRITEBACK);
        bus.pc_we   = (state_q == ST_WRITEBACK);
        bus.reg_we  = (state_q == ST_WRITEBACK) && op_writes_reg(bus.opcode);
        bus.state   = state_q;
        bus.busy    = active;
        bus.retired = retired_q;
        bus.illegal = illegal_q;
        bus.timeout = timeout_q;
    end

endmodule
